// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encoding, Nk/Nr lookup, S-box and xtime.
package aes_pkg;

  localparam int AES_MAX_NK = 8;
  localparam int AES_MAX_NR = 14;

  localparam logic [1:0] KL_128  = 2'b00;
  localparam logic [1:0] KL_192  = 2'b01;
  localparam logic [1:0] KL_256  = 2'b10;
  localparam logic [1:0] KL_RSVD = 2'b11;

  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Entry 0 sits in the top byte; row n holds S-box outputs 16n..16n+15.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = 11'd2047 - {x, 3'b000};
    return SBOX_TBL[base -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lanes, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign word_o[8*g +: 8] = sbox(word_i[8*g +: 8]);
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128/192/256 key schedule: one word per clock into a round-key array.
// Optional AES_KEYEXP_ZEROIZE_EN adds a zeroize_i port that wipes storage and aborts a job.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter  int MAX_NK = AES_MAX_NK,
  parameter  int MAX_NR = AES_MAX_NR,
  localparam int NW     = 4 * (MAX_NR + 1),
  localparam int IW     = $clog2(NW),
  localparam int RIW    = $clog2(MAX_NR + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef AES_KEYEXP_ZEROIZE_EN
  input  logic                  zeroize_i,
`endif
  input  logic                  start_i,
  input  logic [1:0]            key_len_i,
  input  logic [32*MAX_NK-1:0]  key_in_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o,
  input  logic [RIW-1:0]        rd_idx_i,
  output rkey_t                 rd_data_o,
  output logic                  rd_valid_o
);

  state_e        state_q, state_d;
  logic [IW-1:0] i_q;
  logic [3:0]    nk_q, nr_q, modk_q;
  logic [7:0]    rcon_q;
  logic          keys_valid_q, done_q, cfg_err_q;
  logic [31:0]   w_q [NW];

  logic          zap, kl_ok, ld_key, last;
  logic [3:0]    nk_in;
  logic [31:0]   t_prev, sub_in, sub_out, t, w_new;
  logic [IW-1:0] rd_base;

`ifdef AES_KEYEXP_ZEROIZE_EN
  assign zap = zeroize_i;
`else
  assign zap = 1'b0;
`endif

  assign kl_ok  = (key_len_i != KL_RSVD);
  assign nk_in  = nk_of(key_len_i);
  assign ld_key = (state_q == ST_IDLE) && start_i && kl_ok;
  assign last   = (int'(i_q) == 4 * int'(nr_q) + 3);

  // Shared SubWord: RotWord input on Nk boundaries, plain word on the AES-256 mid-point.
  assign t_prev = w_q[i_q - IW'(1)];
  assign sub_in = (modk_q == 4'd0) ? {t_prev[23:0], t_prev[31:24]} : t_prev;

  aes_subword u_subword (.word_i(sub_in), .word_o(sub_out));

  always_comb begin
    t = t_prev;
    if (modk_q == 4'd0)                     t = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && modk_q == 4'd4) t = sub_out;
  end

  assign w_new = w_q[i_q - IW'(nk_q)] ^ t;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_i && kl_ok) state_d = ST_EXPAND;
      ST_EXPAND: if (last)             state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
    if (zap) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      i_q          <= '0;
      modk_q       <= 4'd0;
      nk_q         <= 4'd4;
      nr_q         <= 4'd10;
      rcon_q       <= 8'h01;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (zap) begin
        keys_valid_q <= 1'b0;
        rcon_q       <= 8'h01;
      end else begin
        case (state_q)
          ST_IDLE: if (start_i) begin
            if (kl_ok) begin
              nk_q         <= nk_in;
              nr_q         <= nr_of(key_len_i);
              i_q          <= IW'(nk_in);
              modk_q       <= 4'd0;
              rcon_q       <= 8'h01;
              keys_valid_q <= 1'b0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          ST_EXPAND: begin
            i_q    <= i_q + IW'(1);
            modk_q <= (modk_q == nk_q - 4'd1) ? 4'd0 : modk_q + 4'd1;
            if (modk_q == 4'd0) rcon_q <= xtime(rcon_q);
          end
          ST_DONE: begin
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Round-key storage carries no reset; stale words stay hidden behind keys_valid.
  always_ff @(posedge clk_i) begin
    if (ld_key) begin
      for (int j = 0; j < MAX_NK; j++)
        if (j < int'(nk_in)) w_q[j] <= key_in_i[32*(MAX_NK-j)-1 -: 32];
    end else if (state_q == ST_EXPAND) begin
      w_q[i_q] <= w_new;
    end
`ifdef AES_KEYEXP_ZEROIZE_EN
    if (zeroize_i)
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
`endif
  end

  assign rd_base = IW'({rd_idx_i, 2'b00});

  always_comb begin
    busy_o     = (state_q == ST_EXPAND);
    done_o     = done_q;
    cfg_err_o  = cfg_err_q;
    rd_valid_o = keys_valid_q && (int'(rd_idx_i) <= int'(nr_q));
    rd_data_o  = '0;
    if (rd_valid_o)
      rd_data_o = {w_q[rd_base], w_q[rd_base + IW'(1)], w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Randomised bench for aes_key_expand_seq against a FIPS-197 style reference model.
module tb_aes_key_expand_seq;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] V128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] V192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] V256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         zeroize = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [255:0] key_in = '0;
  logic         busy, done, cfg_err, rd_valid;
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_data;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aes_key_expand_seq dut (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef AES_KEYEXP_ZEROIZE_EN
    .zeroize_i(zeroize),
`endif
    .start_i(start), .key_len_i(key_len), .key_in_i(key_in),
    .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data), .rd_valid_o(rd_valid));

  // ---------------- reference model ----------------
  logic [7:0]   sb [256];
  logic [127:0] p_rk [15];
  logic [127:0] m_rk [15];
  int p_nr, p_left, m_nr = 10, m_left = 0;
  bit m_valid = 1'b0, m_done = 1'b0, m_cerr = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr, ntot;
    nk = 4 + 2 * int'(kl); nr = nk + 6; ntot = 4 * (nr + 1);
    for (int j = 0; j < nk; j++) w[j] = key[255 - 32*j -: 32];
    rc = 8'h01;
    for (int j = nk; j < ntot; j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && j % nk == 4) begin
        t = subw(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      p_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    p_nr = nr;
    p_left = ntot - nk + 1;
  endtask

  // Model clocked on the same edge as the DUT; m_left counts edges until done.
  initial forever begin
    @(posedge clk);
    m_done = 1'b0; m_cerr = 1'b0;
    if (!rst_n) begin
      m_left = 0; m_valid = 1'b0;
    end else if (zeroize) begin
      m_left = 0; m_valid = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_valid = 1'b1; m_rk = p_rk; m_nr = p_nr;
      end
    end else if (start) begin
      if (key_len == 2'b11) m_cerr = 1'b1;
      else begin
        model_expand(key_in, key_len);
        m_valid = 1'b0; m_left = p_left;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] exp_rd();
    if (m_valid && int'(rd_idx) <= m_nr) return m_rk[rd_idx];
    return 128'h0;
  endfunction

  // Compare process: every cycle once reset has been applied.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cmp_busy",     128'(busy),     128'(m_left >= 2));
      chk("cmp_done",     128'(done),     128'(m_done));
      chk("cmp_cfg_err",  128'(cfg_err),  128'(m_cerr));
      chk("cmp_rd_valid", 128'(rd_valid), 128'(m_valid && int'(rd_idx) <= m_nr));
      chk("cmp_rd_data",  rd_data,        exp_rd());
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_job(input logic [255:0] key, input logic [1:0] kl, input int lat, input int poke);
    int n; bit seen;
    key_in = key; key_len = kl; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; n = 0; seen = 1'b0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1; start = 1'b0;
      end else begin
        @(posedge clk); #2;
        n++;
        rd_idx = 4'($urandom_range(0, 15));
        start = (n == poke);
        if (n == poke) begin
          key_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
          key_len = 2'($urandom_range(0, 3));
        end
      end
    end
    chk("done_latency", 128'(seen ? n : -1), 128'(lat));
    @(posedge clk); #2;
  endtask

  task automatic chk_rd(input string nm, input logic [3:0] idx, input logic v, input logic [127:0] d);
    rd_idx = idx;
    @(negedge clk);
    chk({nm, "_valid"}, 128'(rd_valid), 128'(v));
    chk({nm, "_data"}, rd_data, d);
    @(posedge clk); #2;
  endtask

  function automatic int lat_of(input logic [1:0] kl);
    int nk;
    nk = 4 + 2 * int'(kl);
    return 4 * (nk + 7) - nk + 1;
  endfunction

  initial begin
    logic [255:0] rk;
    logic [1:0]   kl;
    logic         nz;

    build_sbox();
    chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    model_expand(K128, 2'b00);
    chk("model_128_rk1",  p_rk[1],  V128_1);
    chk("model_128_rk10", p_rk[10], V128_10);
    model_expand(K192, 2'b01);
    chk("model_192_rk12", p_rk[12], V192_12);
    model_expand(K256, 2'b10);
    chk("model_256_rk14", p_rk[14], V256_14);

    repeat (3) @(posedge clk);
    #2; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy",     128'(busy),     128'h0);
    chk("rst_done",     128'(done),     128'h0);
    chk("rst_cfg_err",  128'(cfg_err),  128'h0);
    chk("rst_rd_valid", 128'(rd_valid), 128'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // AES-128 vector; a start poked into the DONE cycle must be ignored.
    run_job(K128, 2'b00, 41, 40);
    chk_rd("v128_rk0",  4'd0,  1'b1, K128[255:128]);
    chk_rd("v128_rk1",  4'd1,  1'b1, V128_1);
    chk_rd("v128_rk10", 4'd10, 1'b1, V128_10);
    chk_rd("v128_rk11", 4'd11, 1'b0, 128'h0);

    // AES-192 vector with a start pulse in the middle of expansion.
    run_job(K192, 2'b01, 47, 10);
    chk_rd("v192_rk12", 4'd12, 1'b1, V192_12);
    chk_rd("v192_rk13", 4'd13, 1'b0, 128'h0);

    run_job(K256, 2'b10, 53, 0);
    chk_rd("v256_rk14", 4'd14, 1'b1, V256_14);

    // Reserved key length: cfg_err pulse, old keys stay readable.
    key_len = 2'b11; key_in = ~K256; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    chk("rsvd_cfg_err", 128'(cfg_err), 128'h1);
    chk("rsvd_busy",    128'(busy),    128'h0);
    @(posedge clk); #2;
    chk_rd("rsvd_keep_rk14", 4'd14, 1'b1, V256_14);

    // Reset 20 cycles into an AES-256 job.
    key_len = 2'b10; key_in = K256 ^ {8{32'h5a5a5a5a}}; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    rd_idx = 4'd0;
    @(negedge clk);
    chk("midrst_busy",     128'(busy),     128'h0);
    chk("midrst_rd_valid", 128'(rd_valid), 128'h0);
    repeat (60) begin @(posedge clk); #2; end
    run_job(K128, 2'b00, 41, 0);
    chk_rd("post_rst_rk10", 4'd10, 1'b1, V128_10);

`ifdef AES_KEYEXP_ZEROIZE_EN
    zeroize = 1'b1;
    @(posedge clk); #2;
    zeroize = 1'b0;
    rd_idx = 4'd0;
    @(negedge clk);
    chk("zero_rd_valid", 128'(rd_valid), 128'h0);
    nz = 1'b0;
    for (int k = 0; k < 60; k++) if (dut.w_q[k] != 32'h0) nz = 1'b1;
    chk("zero_storage", 128'(nz), 128'h0);
    @(posedge clk); #2;
    zeroize = 1'b1; start = 1'b1; key_len = 2'b00; key_in = K128;
    @(posedge clk); #2;
    zeroize = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("zero_vs_start_busy", 128'(busy), 128'h0);
    repeat (50) begin @(posedge clk); #2; end
`endif

    // Random jobs, random mid-run pokes, then a full read sweep.
    repeat (10) begin
      for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom();
      kl = 2'($urandom_range(0, 3));
      if (kl == 2'b11) begin
        key_len = kl; key_in = rk; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
      end else begin
        run_job(rk, kl, lat_of(kl), $urandom_range(1, lat_of(kl) - 1));
      end
      for (int i = 0; i < 16; i++) begin
        rd_idx = 4'(i);
        @(posedge clk); #2;
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
